mux_rr_reg: RTL



---
 rtl/mux_rr_reg.sv | 112 +++++++++++
 1 files changed

// File: rtl/mux_rr_reg.sv
// mux_rr_reg: registered CH-channel, WIDTH-bit multiplexer with valid/ready on
// every input channel and on the output. The channel is picked either by a fixed
// select or by round-robin among the valid channels. Adds one register stage.
module mux_rr_reg #(
  parameter int WIDTH = 32,
  parameter int CH    = 4,
  parameter int SELW  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [SELW-1:0]       sel,
  input  logic [CH*WIDTH-1:0]   in_data,
  input  logic [CH-1:0]         in_valid,
  output logic [CH-1:0]         in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SELW-1:0]       grant
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;
  logic [SELW-1:0]  grant_q, grant_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             can_load;
  logic             cand_vld;
  logic [SELW-1:0]  cand_idx;
  logic [WIDTH-1:0] cand_data;
  logic             xfer;

  assign can_load = !vld_q || out_ready;

  // Candidate selection: fixed select (out-of-range means none) or a
  // round-robin scan starting at ptr and wrapping modulo CH.
  always_comb begin
    int idx;
    cand_vld = 1'b0;
    cand_idx = '0;
    idx      = 0;
    if (!mode) begin
      if (int'(sel) < CH) begin
        cand_vld = 1'b1;
        cand_idx = sel;
      end
    end else begin
      for (int k = 0; k < CH; k++) begin
        idx = (int'(ptr_q) + k) % CH;
        if (!cand_vld && in_valid[idx]) begin
          cand_vld = 1'b1;
          cand_idx = SELW'(idx);
        end
      end
    end
  end

  // Ready is one-hot on the candidate when the output buffer can take a word;
  // the candidate's data is steered toward the output register.
  always_comb begin
    in_ready  = '0;
    cand_data = '0;
    for (int i = 0; i < CH; i++) begin
      if (cand_vld && (int'(cand_idx) == i)) begin
        in_ready[i] = can_load;
        cand_data   = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer = |(in_ready & in_valid);

  // Next state of the output buffer and the round-robin pointer.
  always_comb begin
    int nxt;
    data_d  = data_q;
    vld_d   = vld_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    nxt     = int'(cand_idx) + 1;
    if (nxt >= CH) nxt = 0;
    if (xfer) begin
      data_d  = cand_data;
      grant_d = cand_idx;
      vld_d   = 1'b1;
      if (mode) ptr_d = SELW'(nxt);
    end else if (out_ready) begin
      // Drain without refill: data and grant keep their last values.
      vld_d = 1'b0;
    end
  end

  // Output buffer and pointer registers; reset discards any held word at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      vld_q   <= 1'b0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      vld_q   <= vld_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = vld_q;
  assign grant     = grant_q;

endmodule
